// File: rtl/script_pkg.sv
// Shared definitions for the kitchen script engine: instruction layout,
// op/func/i_sign codes, feedback bit map and the sequencer state encoding.
// Used by the sequencer, the wait unit and the action issuer.
package script_pkg;

  // Instruction word layout
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned FUNC_LSB   = 3;
  localparam int unsigned FUNC_W     = 2;
  localparam int unsigned SIGN_LSB   = 5;
  localparam int unsigned SIGN_W     = 3;
  localparam int unsigned NUM_LSB    = 8;
  localparam int unsigned NUM_W      = 8;
  localparam int unsigned FEEDBACK_W = 8;

  // Op codes; any code not listed executes as a nop
  localparam logic [OP_W-1:0] OP_NOP    = 3'b000;
  localparam logic [OP_W-1:0] OP_ACTION = 3'b001;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'b010;
  localparam logic [OP_W-1:0] OP_WAIT   = 3'b011;
  localparam logic [OP_W-1:0] OP_HALT   = 3'b111;

  // Func codes as seen by the wait unit
  localparam logic [FUNC_W-1:0] FUNC_WAIT_MODE      = 2'b00;
  localparam logic [FUNC_W-1:0] FUNC_WAITUNTIL_MODE = 2'b01;

  // Func codes as seen by conditional jumps
  localparam logic [FUNC_W-1:0] FUNC_JMP_IF_SET = 2'b00;
  localparam logic [FUNC_W-1:0] FUNC_JMP_IF_CLR = 2'b01;
  localparam logic [FUNC_W-1:0] FUNC_JMP_ALWAYS = 2'b10;
  localparam logic [FUNC_W-1:0] FUNC_JMP_NEVER  = 2'b11;

  // i_sign codes; codes 1..4 select feedback bits 2..5 in order
  localparam logic [SIGN_W-1:0] SIGN_PLAYER_READY   = 3'd1;
  localparam logic [SIGN_W-1:0] SIGN_PLAYER_HASITEM = 3'd2;
  localparam logic [SIGN_W-1:0] SIGN_TARGET_READY   = 3'd3;
  localparam logic [SIGN_W-1:0] SIGN_TARGET_HASITEM = 3'd4;
  localparam logic [SIGN_W-1:0] SIGN_FB_OFFSET      = 3'd1;

  // Operand fields kept in the instruction register
  typedef struct packed {
    logic [NUM_W-1:0]  num;
    logic [SIGN_W-1:0] sign;
    logic [FUNC_W-1:0] func;
  } operand_t;

  // Full instruction word as read from the script ROM
  typedef struct packed {
    operand_t        opnd;
    logic [OP_W-1:0] op;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC_ACT  = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

endpackage

// File: rtl/sig_select.sv
// Combinational i_sign -> feedback bit mux.
// Ports: sign (i_sign code), feedback (kitchen state bits), sig_c (selected bit,
// 0 for codes outside player_ready..target_hasitem).
module sig_select
  import script_pkg::*;
(
  input  logic [SIGN_W-1:0]     sign,
  input  logic [FEEDBACK_W-1:0] feedback,
  output logic                  sig_c
);

  // Codes 1..4 are contiguous and map to feedback[2..5]
  always_comb begin
    sig_c = 1'b0;
    if (sign >= SIGN_PLAYER_READY && sign <= SIGN_TARGET_HASITEM) begin
      sig_c = feedback[3'(sign + SIGN_FB_OFFSET)];
    end
  end

endmodule

// File: rtl/script_sequencer.sv
// Fetch/decode/dispatch stage of the kitchen script engine.
// Ports: clk/rst_n (sync active-low), start; rom_addr/rom_data to a 1-cycle
// synchronous script ROM; feedback_sig kitchen bits for jumps; wait_* to the
// wait unit (wait_ready back); act_valid/act_code/act_ready handshake to the
// UART action issuer; pc, busy, halted status.
module script_sequencer
  import script_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [INSTR_W-1:0]    rom_data,
  input  logic [FEEDBACK_W-1:0] feedback_sig,
  output logic                  wait_en,
  output logic [NUM_W-1:0]      wait_num,
  output logic [FUNC_W-1:0]     wait_func,
  output logic [SIGN_W-1:0]     wait_sign,
  input  logic                  wait_ready,
  output logic                  act_valid,
  output logic [NUM_W-1:0]      act_code,
  input  logic                  act_ready,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  halted
);

  localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  state_e            state, state_d;
  logic [ADDR_W-1:0] pc_d, pc_inc, rom_addr_d;
  operand_t          ir, ir_d;
  logic [CNT_W-1:0]  settle_cnt, settle_cnt_d;
  logic              settle_done;
  logic              wait_en_d, act_valid_d, busy_d, halted_d;
  instr_t            instr;
  logic              sel_sig;
  logic              jump_taken;

  assign instr       = instr_t'(rom_data);
  assign pc_inc      = pc + ADDR_W'(1);
  assign settle_done = (settle_cnt >= CNT_W'(SETTLE));

  // Wait/action fields come straight from the instruction register flops
  assign wait_num  = ir.num;
  assign wait_func = ir.func;
  assign wait_sign = ir.sign;
  assign act_code  = ir.num;

  sig_select u_sig_select (
    .sign     (instr.opnd.sign),
    .feedback (feedback_sig),
    .sig_c    (sel_sig)
  );

  // Jump condition evaluated on the word arriving in DECODE
  always_comb begin
    jump_taken = 1'b0;
    case (instr.opnd.func)
      FUNC_JMP_IF_SET: jump_taken = sel_sig;
      FUNC_JMP_IF_CLR: jump_taken = ~sel_sig;
      FUNC_JMP_ALWAYS: jump_taken = 1'b1;
      default:         jump_taken = 1'b0;
    endcase
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    ir_d         = ir;
    settle_cnt_d = settle_cnt;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d = instr.opnd;
        case (instr.op)
          OP_ACTION: state_d = ST_EXEC_ACT;
          OP_WAIT: begin
            state_d      = ST_EXEC_WAIT;
            settle_cnt_d = '0;
          end
          OP_HALT: state_d = ST_HALT;
          OP_JUMP: begin
            state_d = ST_FETCH;
            pc_d    = jump_taken ? ADDR_W'(instr.opnd.num) : pc_inc;
          end
          default: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
          end
        endcase
      end
      ST_EXEC_ACT: begin
        if (act_ready) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      ST_EXEC_WAIT: begin
        // wait_ready is only trusted once the settle counter has saturated
        if (settle_done && wait_ready) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end else if (!settle_done) begin
          settle_cnt_d = settle_cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // rom_addr tracks pc so the FETCH cycle presents the current address
    rom_addr_d  = pc_d;
    wait_en_d   = (state_d == ST_EXEC_WAIT);
    act_valid_d = (state_d == ST_EXEC_ACT);
    halted_d    = (state_d == ST_HALT);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= '0;
      rom_addr   <= '0;
      ir         <= '0;
      settle_cnt <= '0;
      wait_en    <= 1'b0;
      act_valid  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      rom_addr   <= rom_addr_d;
      ir         <= ir_d;
      settle_cnt <= settle_cnt_d;
      wait_en    <= wait_en_d;
      act_valid  <= act_valid_d;
      busy       <= busy_d;
      halted     <= halted_d;
    end
  end

endmodule

// File: tb/tb_script_sequencer.sv
// Scoreboard bench for script_sequencer: an instruction-level interpreter
// predicts the action/wait/halt events of a program, a negedge monitor pops and
// compares them as the DUT presents them.
module tb_script_sequencer;

  localparam int SETTLE = 2;
  localparam logic [1:0] K_ACT  = 2'd1;
  localparam logic [1:0] K_WAIT = 2'd2;
  localparam logic [1:0] K_HALT = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] pc;
    logic [7:0] num;
    logic [1:0] func;
    logic [2:0] sign;
  } ev_t;

  logic        clk, rst_n, start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  feedback_sig;
  logic        wait_en, wait_ready, act_valid, act_ready, busy, halted;
  logic [7:0]  wait_num, act_code, pc;
  logic [1:0]  wait_func;
  logic [2:0]  wait_sign;

  logic [15:0] rom [256];
  ev_t         exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, start_cyc = 0, halt_cyc = 0, act_hold = 0, wait_len = 0;
  logic [7:0]  halt_pc = '0;
  int          act_mode = 2, wait_mode = 2;  // 0 random, 1 low, 2 high

  script_sequencer #(.ADDR_W(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .feedback_sig(feedback_sig), .wait_en(wait_en),
    .wait_num(wait_num), .wait_func(wait_func), .wait_sign(wait_sign),
    .wait_ready(wait_ready), .act_valid(act_valid), .act_code(act_code),
    .act_ready(act_ready), .pc(pc), .busy(busy), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous script ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Handshake responders, changed just after each rising edge
  initial begin
    act_ready  = 1'b0;
    wait_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (act_mode)
        0: act_ready = 1'($urandom_range(0, 1));
        1: act_ready = 1'b0;
        default: act_ready = 1'b1;
      endcase
      case (wait_mode)
        0: wait_ready = ($urandom_range(0, 2) != 0);
        1: wait_ready = 1'b0;
        default: wait_ready = 1'b1;
      endcase
    end
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void score(ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'(got), 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("event", 32'(got), 32'(e));
    end
  endfunction

  // Instruction-level reference: walk the program and list its visible events
  task automatic model_load(input int limit);
    int         p;
    logic [15:0] w;
    logic       s, take;
    ev_t        e;
    p = 0;
    for (int n = 0; n < limit; n++) begin
      w = rom[p];
      e = '0;
      e.pc = 8'(p);
      if (w[2:0] == 3'b111) begin
        e.kind = K_HALT;
        exp_q.push_back(e);
        break;
      end
      case (w[2:0])
        3'b001: begin
          e.kind = K_ACT; e.num = w[15:8];
          exp_q.push_back(e);
          p = (p + 1) % 256;
        end
        3'b011: begin
          e.kind = K_WAIT; e.num = w[15:8]; e.func = w[4:3]; e.sign = w[7:5];
          exp_q.push_back(e);
          p = (p + 1) % 256;
        end
        3'b010: begin
          case (w[7:5])
            3'd1: s = feedback_sig[2];
            3'd2: s = feedback_sig[3];
            3'd3: s = feedback_sig[4];
            3'd4: s = feedback_sig[5];
            default: s = 1'b0;
          endcase
          case (w[4:3])
            2'd0: take = s;
            2'd1: take = !s;
            2'd2: take = 1'b1;
            default: take = 1'b0;
          endcase
          p = take ? int'(w[15:8]) : (p + 1) % 256;
        end
        default: p = (p + 1) % 256;
      endcase
    end
  endtask

  // Monitor
  logic       act_prev = 0, act_exit = 0, wait_prev = 0, wait_exit = 0, halted_prev = 0;
  logic [7:0] act_code_q;
  logic [21:0] wait_q;
  int         act_run = 0, wait_idx = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      act_prev = 0; act_exit = 0; wait_prev = 0; wait_exit = 0; halted_prev = 0;
    end else begin
      if (act_exit) begin
        check("act_release", 32'(act_valid), 32'h0);
        act_exit = 0;
        act_prev = 0;
      end else begin
        if (act_prev) check("act_stable", 32'({act_valid, act_code}), 32'({1'b1, act_code_q}));
        if (act_valid) begin
          if (!act_prev) begin act_code_q = act_code; act_run = 0; end
          act_run++;
          if (act_ready) begin
            score('{kind: K_ACT, pc: pc, num: act_code, func: 2'b0, sign: 3'b0});
            act_hold = act_run;
            act_exit = 1;
          end
          act_prev = 1;
        end else act_prev = 0;
      end

      if (wait_exit) begin
        check("wait_release", 32'(wait_en), 32'h0);
        wait_exit = 0;
        wait_prev = 0;
      end else begin
        if (wait_prev)
          check("wait_stable", 32'({wait_en, wait_num, wait_func, wait_sign, pc}),
                32'({1'b1, wait_q[20:0]}));
        if (wait_en) begin
          if (!wait_prev) begin
            wait_q = {1'b1, wait_num, wait_func, wait_sign, pc};
            wait_idx = 0;
          end
          if (wait_idx >= SETTLE && wait_ready) begin
            score('{kind: K_WAIT, pc: pc, num: wait_num, func: wait_func, sign: wait_sign});
            wait_len = wait_idx + 1;
            wait_exit = 1;
          end
          wait_idx++;
          wait_prev = 1;
        end else wait_prev = 0;
      end

      if (halted && !halted_prev) begin
        score('{kind: K_HALT, pc: pc, num: 8'h0, func: 2'b0, sign: 3'b0});
        halt_cyc = cyc;
        halt_pc = pc;
      end
      halted_prev = halted;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(posedge clk);
    check("events_pending", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  int bad;
  logic [7:0] pc255, pc0;

  initial begin
    rst_n = 1'b0; start = 1'b0; feedback_sig = 8'h00;
    clear_rom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({pc, rom_addr, busy, halted, act_valid, wait_en}), 32'h0);
    check("reset_fields", 32'({wait_num, wait_func, wait_sign, act_code}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // start and reset on the same edge: reset wins
    @(posedge clk); #1 rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("reset_beats_start", 32'({busy, pc}), 32'h0);

    // Nop run: pc steps every two cycles and wraps
    do_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (pc !== 8'(((c - 1) / 2) % 256) || busy !== 1'b1) bad++;
      if (c == 511) pc255 = pc;
      if (c == 513) pc0 = pc;
    end
    check("nop_pc_trace", 32'(bad), 32'h0);
    check("nop_pc_wrap", 32'({pc255, pc0}), 32'h0000FF00);

    // Action handshake held against a stalled issuer
    do_reset();
    rom[0] = 16'h2A01; rom[1] = 16'h0007;
    act_mode = 1;
    model_load(10);
    pulse_start();
    for (int i = 0; i < 50 && !act_valid; i++) @(negedge clk);
    check("act_seen", 32'(act_valid), 32'h1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 act_mode = 2;
    wait_done(100);
    check("act_hold_cycles", 32'(act_hold), 32'd4);
    check("act_halt_pc", 32'(halt_pc), 32'h1);

    // Wait settle with wait_ready high throughout
    do_reset();
    rom[0] = 16'h0503;
    wait_mode = 2;
    model_load(10);
    pulse_start();
    wait_done(100);
    check("wait_settle_len", 32'(wait_len), 32'(SETTLE + 1));

    // Wait hold with wait_ready low
    do_reset();
    wait_mode = 1;
    model_load(10);
    pulse_start();
    for (int i = 0; i < 50 && !wait_en; i++) @(negedge clk);
    check("wait_seen", 32'(wait_en), 32'h1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wait_en || pc !== 8'h00) bad++;
      @(negedge clk);
    end
    check("wait_hold", 32'(bad), 32'h0);
    @(posedge clk); #1 wait_mode = 2;
    wait_done(100);

    // Conditional jumps
    clear_rom();
    rom[3] = 16'h1042; rom[4] = 16'h0007; rom[16] = 16'h0007;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      if (t == 2) rom[3] = 16'h10CA;
      feedback_sig = (t == 1) ? 8'hF7 : (t == 0 ? 8'h08 : 8'hFF);
      model_load(20);
      pulse_start();
      wait_done(200);
      check("jump_halt_pc", 32'(halt_pc), (t == 1) ? 32'h04 : 32'h10);
    end

    // Halt, start ignored while busy, restart from HALT
    clear_rom();
    rom[7] = 16'h0007;
    do_reset();
    model_load(20);
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);
    check("halt_latency", 32'(halt_cyc - start_cyc), 32'd17);
    check("halt_pc", 32'({halted, halt_pc}), 32'h107);
    model_load(20);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("restart", 32'({busy, halted, pc}), 32'h200);
    wait_done(200);

    // Reset in the middle of an action
    clear_rom();
    rom[0] = 16'h2A01;
    do_reset();
    act_mode = 1;
    pulse_start();
    for (int i = 0; i < 50 && !act_valid; i++) @(negedge clk);
    check("act_seen_rst", 32'(act_valid), 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("act_reset_drop", 32'({act_valid, busy, halted, pc}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random programs against the reference interpreter
    act_mode = 0; wait_mode = 0;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 256; i++) begin
        logic [15:0] w;
        int k;
        w = 16'($urandom);
        k = $urandom_range(0, 19);
        if (k < 3)       w[2:0] = 3'($urandom_range(4, 6));
        else if (k < 7)  w[2:0] = 3'b001;
        else if (k < 11) w[2:0] = 3'b011;
        else if (k < 18) w[2:0] = 3'b010;
        else if (k < 19) w[2:0] = 3'b000;
        else             w[2:0] = 3'b111;
        rom[i] = w;
      end
      feedback_sig = 8'($urandom);
      do_reset();
      model_load(150);
      pulse_start();
      wait_done(8000);
    end

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/script_sequencer.md
# script_sequencer

Fetch/decode/dispatch stage of the kitchen script engine. It steps a program counter through the script ROM and decodes each 16-bit instruction. Wait instructions go to the wait unit, which returns `is_ready`. Action instructions go to the UART action issuer over a valid/ready handshake. Conditional jumps are resolved internally against the kitchen feedback bits.

## Interface
Parameters:
- `ADDR_W`, 8: script ROM address width; PC wraps modulo 2^ADDR_W.
- `SETTLE`, 2: cycles `wait_en` is held before `wait_ready` is trusted.

Ports:
- `clk`  in  1  uart_clk domain clock, single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level/pulse; begins execution from PC 0 when IDLE or HALT.
- `rom_addr`  out  ADDR_W  script ROM address (synchronous ROM, 1-cycle read latency).
- `rom_data`  in  16  instruction word.
- `feedback_sig`  in  8  kitchen state bits.
- `wait_en`  out  1  enable to wait unit.
- `wait_num`  out  8  i_num field to wait unit.
- `wait_func`  out  2  func field to wait unit.
- `wait_sign`  out  3  i_sign field to wait unit.
- `wait_ready`  in  1  wait unit `is_ready`.
- `act_valid`  out  1  action request valid.
- `act_code`  out  8  action operand (i_num).
- `act_ready`  in  1  action issuer accept.
- `pc`  out  ADDR_W  current instruction address.
- `busy`  out  1  high in any state except IDLE/HALT.
- `halted`  out  1  high in HALT.

## Operation
- Instruction fields:
  - [2:0] op.
  - [4:3] func.
  - [7:5] i_sign.
  - [15:8] i_num.
- Op codes:
  - 000 nop.
  - 001 action.
  - 010 jump.
  - 011 wait.
  - 111 halt.
  - Others execute as nop.
- States: IDLE, FETCH, DECODE, EXEC_ACT, EXEC_WAIT, HALT.
- IDLE/HALT + `start` → FETCH with pc=0.
- FETCH: drive `rom_addr`=pc → DECODE.
- DECODE: latch `rom_data` into the instruction register, then branch on op:
  - nop: pc+1 → FETCH.
  - halt: → HALT, pc unchanged.
  - action: → EXEC_ACT.
  - wait: → EXEC_WAIT, settle counter cleared.
  - jump: evaluate the selected signal `s`:
    - func 00: jump if s=1.
    - func 01: jump if s=0.
    - func 10: unconditional.
    - func 11: never jump.
    - Taken: pc = i_num[ADDR_W-1:0]. Not taken: pc+1. Then → FETCH.
- Signal select by i_sign:
  - 1 → feedback[2] (player_ready).
  - 2 → feedback[3] (player_hasitem).
  - 3 → feedback[4] (target_ready).
  - 4 → feedback[5] (target_hasitem).
  - Any other code → 0.
- EXEC_ACT: `act_valid`=1, `act_code`=i_num, both stable until `act_ready`. On the transfer cycle: pc+1 → FETCH.
- EXEC_WAIT:
  - `wait_en`=1 with fields driven from the instruction register.
  - The settle counter counts while in state; `wait_ready` is ignored until the counter reaches SETTLE.
  - After that, `wait_ready`=1 → pc+1 → FETCH, with `wait_en` dropping on the same edge.
- `start` outside IDLE/HALT is ignored.
- PC increment wraps from 2^ADDR_W−1 to 0.

## Timing
- Reset: state IDLE; pc=0; rom_addr=0; wait_en=0; act_valid=0; busy=0; halted=0; wait_num/func/sign=0; act_code=0; instruction register=0.
- Reset asserted mid-instruction returns to IDLE on the next edge and drops all requests.
- Nop/jump: 2 cycles per instruction (FETCH, DECODE).
- Action: 2 cycles + handshake cycles; minimum 3 when `act_ready` is already high.
- Wait: 2 cycles + at least SETTLE+1 cycles in EXEC_WAIT.
- `wait_en` and `wait_*` fields are registered outputs; they are valid from the first EXEC_WAIT cycle and remain constant throughout it.
- Jump condition uses `feedback_sig` sampled in the DECODE cycle.
- `start` and `rst_n` low on the same edge: reset wins.

## Structure
- Package `script_pkg`:
  - Op codes.
  - Func codes (wait_mode, waituntil_mode, jump conditions).
  - i_sign codes (player_ready, player_hasitem, target_ready, target_hasitem).
  - State enum.
  - Field bit positions.
  - Shared with the wait and action units.
- Sub-module `sig_select`: combinational i_sign → feedback bit mux. It is reused by the wait unit.

## Test plan
- Nop run: ROM of nops, `start` pulse → pc steps 0,1,2… every 2 cycles and wraps 255→0.
- Action handshake: ROM[0]=action i_num=0x2A, `act_ready` low 3 cycles → act_valid/act_code=0x2A held stable 4 cycles, then pc=1.
- Wait settle: ROM[0]=wait i_num=5, `wait_ready` high throughout → stays in EXEC_WAIT exactly SETTLE+1 cycles.
- Wait hold: with `wait_ready` low for 20 cycles, wait_en stays high for the 20 cycles and pc stays at 0.
- Jump: ROM[3]=jump func 00, i_sign=2, i_num=0x10, feedback[3]=1 → pc=0x10. The same instruction with feedback[3]=0 → pc=4. i_sign=6 with func 01 → taken.
- Halt/reset: halt at ROM[7] → halted=1, pc=7, start ignored while busy. A `start` in HALT restarts at pc=0. `rst_n` low during EXEC_ACT → act_valid=0 next cycle, state IDLE.
